// File: rtl/fc_sched_pkg.sv
// fc_sched_pkg: shared definitions for the fully-connected layer sequencer.
//   - fc_state_e : sequencer FSM states
//   - FC_K / FC_G / FC_KPB : K, G and K/PI for the default layer shape
//   - fc_k / fc_g / fc_kpb : the same quantities for any parameter set
//   - fc_cnt_w / fc_k_w / fc_g_w / fc_bank_w : counter width helpers
package fc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } fc_state_e;

  localparam int FC_INNEURON_DEF  = 800;
  localparam int FC_OUTNEURON_DEF = 500;
  localparam int FC_PI_DEF        = 4;
  localparam int FC_PO_DEF        = 2;

  localparam int FC_K   = FC_INNEURON_DEF / 2;
  localparam int FC_G   = FC_OUTNEURON_DEF / FC_PO_DEF;
  localparam int FC_KPB = FC_K / FC_PI_DEF;

  // Reads per output group: each input RAM port covers half the neurons.
  function automatic int fc_k(input int inneuron);
    return inneuron / 2;
  endfunction

  // Number of output groups.
  function automatic int fc_g(input int outneuron, input int po);
    return outneuron / po;
  endfunction

  // Elements of k that live in one input bank.
  function automatic int fc_kpb(input int inneuron, input int pi);
    return (inneuron / 2) / pi;
  endfunction

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int fc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int fc_k_w(input int inneuron);
    return fc_cnt_w(inneuron / 2);
  endfunction

  function automatic int fc_g_w(input int outneuron, input int po);
    return fc_cnt_w(outneuron / po);
  endfunction

  function automatic int fc_bank_w(input int pi);
    return fc_cnt_w(pi);
  endfunction

endpackage

// File: rtl/fc_sched_delay.sv
// fc_sched_delay: RD_LAT-deep shift register that re-aligns the read-side
// control {valid, first, bank} with data returning from the BRAMs.
// Ports: clock, reset (sync, active-high), valid_in/first_in/bank_in from the
// issue side, valid_out/first_out/bank_out aligned to the BRAM output.
module fc_sched_delay
  import fc_sched_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int BANK_W = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              first_in,
  input  logic [BANK_W-1:0] bank_in,
  output logic              valid_out,
  output logic              first_out,
  output logic [BANK_W-1:0] bank_out
);

  logic [RD_LAT-1:0] valid_r;
  logic [RD_LAT-1:0] first_r;
  logic [BANK_W-1:0] bank_r [RD_LAT];

  // Shift the control tuple one stage per cycle; reset empties the line.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= '0;
      first_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        bank_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= valid_in;
      first_r[0] <= first_in;
      bank_r[0]  <= bank_in;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        first_r[i] <= first_r[i-1];
        bank_r[i]  <= bank_r[i-1];
      end
    end
  end

  assign valid_out = valid_r[RD_LAT-1];
  assign first_out = first_r[RD_LAT-1];
  assign bank_out  = bank_r[RD_LAT-1];

endmodule

// File: rtl/fc_layer_sched.sv
// fc_layer_sched: sequencer for one fully-connected layer.
// On start it walks every output group: K cycles of input/weight reads,
// a drain while the MAC pipeline empties, then one output-buffer write
// (held off by out_full). done pulses after the last group.
// Ports: clock/reset (sync, active-high); start/busy/done handshake;
// in_rd_en/in_addr_a/in_addr_b and w_rd_en/w_addr to the BRAMs;
// bank_sel/accum_en/accum_sload to the PI mux and MAC lanes;
// out_full/out_wr_en/out_addr to the output buffer.
// Optional macro FC_SCHED_PERF_EN adds perf_cycles (busy cycles) and
// perf_stall (cycles in WRITE blocked by out_full), 32-bit saturating.
module fc_layer_sched
  import fc_sched_pkg::*;
#(
  parameter int INNEURON                = 800,
  parameter int OUTNEURON               = 500,
  parameter int PI                      = 4,
  parameter int PO                      = 2,
  parameter int FC_INNEURON_ADDR_WIDTH  = 10,
  parameter int FC_WEIGHT_ADDR_WIDTH    = 16,
  parameter int FC_OUTNEURON_ADDR_WIDTH = 9,
  parameter int RD_LAT                  = 2,
  parameter int ACC_LAT                 = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               in_rd_en,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0]  in_addr_a,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0]  in_addr_b,
  output logic                               w_rd_en,
  output logic [FC_WEIGHT_ADDR_WIDTH-1:0]    w_addr,
  output logic [fc_bank_w(PI)-1:0]           bank_sel,
  output logic                               accum_en,
  output logic                               accum_sload,
  input  logic                               out_full,
  output logic                               out_wr_en,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] out_addr
`ifdef FC_SCHED_PERF_EN
  ,
  output logic [31:0]                        perf_cycles,
  output logic [31:0]                        perf_stall
`endif
);

  localparam int K          = fc_k(INNEURON);
  localparam int G          = fc_g(OUTNEURON, PO);
  localparam int KPB        = fc_kpb(INNEURON, PI);
  localparam int KW         = fc_k_w(INNEURON);
  localparam int GW         = fc_g_w(OUTNEURON, PO);
  localparam int BW         = fc_bank_w(PI);
  localparam int DW         = fc_cnt_w(RD_LAT + ACC_LAT);
  localparam int DRAIN_INIT = RD_LAT + ACC_LAT - 1;

  fc_state_e         state_r, state_nxt;
  logic [KW-1:0]     k_r, k_nxt;
  logic [GW-1:0]     grp_r, grp_nxt;
  logic [DW-1:0]     wait_r, wait_nxt;

  logic                              rd_en_s;
  logic                              first_s;
  logic [BW-1:0]                     bank_s;
  logic [FC_INNEURON_ADDR_WIDTH-1:0] in_addr_s;
  logic [FC_WEIGHT_ADDR_WIDTH-1:0]   w_addr_s;

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      k_r     <= '0;
      grp_r   <= '0;
      wait_r  <= '0;
    end else begin
      state_r <= state_nxt;
      k_r     <= k_nxt;
      grp_r   <= grp_nxt;
      wait_r  <= wait_nxt;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_nxt = state_r;
    k_nxt     = k_r;
    grp_nxt   = grp_r;
    wait_nxt  = wait_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          k_nxt     = '0;
          grp_nxt   = '0;
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (k_r == KW'(K - 1)) begin
          k_nxt     = '0;
          wait_nxt  = DW'(DRAIN_INIT);
          state_nxt = ST_DRAIN;
        end else begin
          k_nxt = k_r + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (wait_r == '0) begin
          state_nxt = ST_WRITE;
        end else begin
          wait_nxt = wait_r - DW'(1);
        end
      end
      ST_WRITE: begin
        if (!out_full) begin
          if (grp_r == GW'(G - 1)) begin
            state_nxt = ST_FIN;
          end else begin
            grp_nxt   = grp_r + GW'(1);
            state_nxt = ST_FETCH;
          end
        end else begin
          state_nxt = ST_WRITE;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read-side address generation; everything is zero outside FETCH so the
  // delay line carries bank 0 on idle slots.
  always_comb begin
    rd_en_s = (state_r == ST_FETCH);
    if (rd_en_s) begin
      first_s   = (k_r == '0);
      bank_s    = BW'(32'(k_r) / 32'(KPB));
      in_addr_s = FC_INNEURON_ADDR_WIDTH'(32'(k_r) % 32'(KPB));
      w_addr_s  = FC_WEIGHT_ADDR_WIDTH'(32'(grp_r) * 32'(K) + 32'(k_r));
    end else begin
      first_s   = 1'b0;
      bank_s    = '0;
      in_addr_s = '0;
      w_addr_s  = '0;
    end
  end

  fc_sched_delay #(
    .RD_LAT (RD_LAT),
    .BANK_W (BW)
  ) u_delay (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (rd_en_s),
    .first_in  (first_s),
    .bank_in   (bank_s),
    .valid_out (accum_en),
    .first_out (accum_sload),
    .bank_out  (bank_sel)
  );

  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_FIN);
  assign in_rd_en  = rd_en_s;
  assign w_rd_en   = rd_en_s;
  assign in_addr_a = in_addr_s;
  assign in_addr_b = in_addr_s;
  assign w_addr    = w_addr_s;
  assign out_wr_en = (state_r == ST_WRITE) && !out_full;
  assign out_addr  = (state_r == ST_WRITE) ? FC_OUTNEURON_ADDR_WIDTH'(grp_r) : '0;

`ifdef FC_SCHED_PERF_EN
  // Saturating activity counters, cleared by an accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cycles <= 32'd0;
      perf_stall  <= 32'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      perf_cycles <= 32'd0;
      perf_stall  <= 32'd0;
    end else begin
      if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if ((state_r == ST_WRITE) && out_full && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fc_layer_sched.sv
// tb_fc_layer_sched: directed scoreboard bench for fc_layer_sched in the
// small configuration (INNEURON=8, OUTNEURON=4, PI=2, PO=2), with a second
// instance at RD_LAT=1. Expected read/accumulate/write/done events are
// pushed when a run is started and popped as the DUT produces them.
module tb_fc_layer_sched;

  localparam int TB_K      = 4;   // INNEURON/2
  localparam int TB_G      = 2;   // OUTNEURON/PO
  localparam int TB_KPB    = 2;   // K/PI
  localparam int TB_RDLAT  = 2;
  localparam int TB_ACCLAT = 1;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  ev_t rd_q[$];
  ev_t acc_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  ev_t mon_e;
  int  mon_d;

  // ---------------- DUT 0 (RD_LAT = 2) ----------------
  logic        reset, start, out_full;
  logic        busy, done, in_rd_en, w_rd_en, accum_en, accum_sload, out_wr_en;
  logic [9:0]  in_addr_a, in_addr_b;
  logic [15:0] w_addr;
  logic [0:0]  bank_sel;
  logic [8:0]  out_addr;
`ifdef FC_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  fc_layer_sched #(
    .INNEURON(8), .OUTNEURON(4), .PI(2), .PO(2),
    .FC_INNEURON_ADDR_WIDTH(10), .FC_WEIGHT_ADDR_WIDTH(16), .FC_OUTNEURON_ADDR_WIDTH(9),
    .RD_LAT(TB_RDLAT), .ACC_LAT(TB_ACCLAT)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_rd_en(in_rd_en), .in_addr_a(in_addr_a), .in_addr_b(in_addr_b),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .bank_sel(bank_sel),
    .accum_en(accum_en), .accum_sload(accum_sload),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_addr(out_addr)
`ifdef FC_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  // ---------------- DUT 1 (RD_LAT = 1) ----------------
  logic        reset1, start1, out_full1;
  logic        busy1, done1, in_rd_en1, w_rd_en1, accum_en1, accum_sload1, out_wr_en1;
  logic [9:0]  in_addr_a1, in_addr_b1;
  logic [15:0] w_addr1;
  logic [0:0]  bank_sel1;
  logic [8:0]  out_addr1;
`ifdef FC_SCHED_PERF_EN
  logic [31:0] perf_cycles1, perf_stall1;
`endif

  fc_layer_sched #(
    .INNEURON(8), .OUTNEURON(4), .PI(2), .PO(2),
    .FC_INNEURON_ADDR_WIDTH(10), .FC_WEIGHT_ADDR_WIDTH(16), .FC_OUTNEURON_ADDR_WIDTH(9),
    .RD_LAT(1), .ACC_LAT(1)
  ) u_dut1 (
    .clock(clock), .reset(reset1), .start(start1), .busy(busy1), .done(done1),
    .in_rd_en(in_rd_en1), .in_addr_a(in_addr_a1), .in_addr_b(in_addr_b1),
    .w_rd_en(w_rd_en1), .w_addr(w_addr1), .bank_sel(bank_sel1),
    .accum_en(accum_en1), .accum_sload(accum_sload1),
    .out_full(out_full1), .out_wr_en(out_wr_en1), .out_addr(out_addr1)
`ifdef FC_SCHED_PERF_EN
    , .perf_cycles(perf_cycles1), .perf_stall(perf_stall1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance to #1 after the posedge that begins bench cycle n.
  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Expected events of one layer run started in cycle t0; stall0 extra
  // WRITE cycles on group 0; events after cycle 'limit' are not expected.
  task automatic push_run(input int t0, input int stall0, input int limit);
    int c;
    int w;
    ev_t e;
    c = t0 + 1;
    for (int g = 0; g < TB_G; g++) begin
      for (int k = 0; k < TB_K; k++) begin
        e.cyc = c + k; e.a = g * TB_K + k; e.b = k % TB_KPB;
        if (e.cyc <= limit) rd_q.push_back(e);
        e.cyc = c + k + TB_RDLAT; e.a = (k == 0) ? 1 : 0; e.b = k / TB_KPB;
        if (e.cyc <= limit) acc_q.push_back(e);
      end
      w = c + TB_K + TB_RDLAT + TB_ACCLAT + ((g == 0) ? stall0 : 0);
      e.cyc = w; e.a = g; e.b = 0;
      if (w <= limit) wr_q.push_back(e);
      c = w + 1;
    end
    if (c <= limit) done_q.push_back(c);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_rd_left"},   64'(rd_q.size()),   64'd0);
    check({tag, "_acc_left"},  64'(acc_q.size()),  64'd0);
    check({tag, "_wr_left"},   64'(wr_q.size()),   64'd0);
    check({tag, "_done_left"}, 64'(done_q.size()), 64'd0);
    check({tag, "_idle"},      64'(busy),          64'd0);
    rd_q.delete(); acc_q.delete(); wr_q.delete(); done_q.delete();
  endtask

  // Scoreboard monitor for DUT 0, sampled mid-cycle.
  always @(negedge clock) begin
    check("w_rd_en_eq", 64'(w_rd_en), 64'(in_rd_en));
    if (accum_sload && !accum_en) check("sload_wo_en", 64'd1, 64'd0);
    if (in_rd_en) begin
      if (rd_q.size() == 0) check("rd_unexpected", 64'(cyc), 64'd0);
      else begin
        mon_e = rd_q.pop_front();
        check("rd_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("w_addr", 64'(w_addr), 64'(mon_e.a));
        check("in_addr_a", 64'(in_addr_a), 64'(mon_e.b));
        check("in_addr_b", 64'(in_addr_b), 64'(mon_e.b));
      end
    end
    if (accum_en) begin
      if (acc_q.size() == 0) check("acc_unexpected", 64'(cyc), 64'd0);
      else begin
        mon_e = acc_q.pop_front();
        check("acc_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("accum_sload", 64'(accum_sload), 64'(mon_e.a));
        check("bank_sel", 64'(bank_sel), 64'(mon_e.b));
      end
    end
    if (out_wr_en) begin
      if (wr_q.size() == 0) check("wr_unexpected", 64'(cyc), 64'd0);
      else begin
        mon_e = wr_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("out_addr", 64'(out_addr), 64'(mon_e.a));
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("done_unexpected", 64'(cyc), 64'd0);
      else begin
        mon_d = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_d));
        check("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  initial begin
    int t0;
    int t1;
    reset = 1'b1; start = 1'b0; out_full = 1'b0;
    reset1 = 1'b1; start1 = 1'b0; out_full1 = 1'b0;
    wait_to(3);
    check("reset_outs", {busy, done, in_rd_en, w_rd_en, accum_en, accum_sload, out_wr_en,
                         bank_sel, in_addr_a, in_addr_b, w_addr, out_addr}, 64'd0);
    check("reset_outs1", {busy1, done1, in_rd_en1, accum_en1, accum_sload1, out_wr_en1,
                          w_addr1, out_addr1}, 64'd0);
`ifdef FC_SCHED_PERF_EN
    check("reset_perf", {perf_cycles, perf_stall}, 64'd0);
`endif
    reset = 1'b0; reset1 = 1'b0;
    wait_to(cyc + 2);

    // 1. nominal run
    t0 = cyc; push_run(t0, 0, 1000000); start = 1'b1;
    wait_to(t0 + 1); start = 1'b0;
    check("s1_busy_c1", 64'(busy), 64'd1);
    wait_to(t0 + 17);
    check("s1_busy_c17", 64'(busy), 64'd1);
    wait_to(t0 + 18);
    check_drained("s1");
`ifdef FC_SCHED_PERF_EN
    check("s1_perf_cycles", perf_cycles, 64'd17);
    check("s1_perf_stall", perf_stall, 64'd0);
`endif
    wait_to(cyc + 2);

    // 2. back-pressure in cycles 8-10
    t0 = cyc; push_run(t0, 3, 1000000); start = 1'b1;
    wait_to(t0 + 1); start = 1'b0;
    wait_to(t0 + 8); out_full = 1'b1;
    wait_to(t0 + 11); out_full = 1'b0;
    wait_to(t0 + 21);
    check_drained("s2");
`ifdef FC_SCHED_PERF_EN
    check("s2_perf_stall", perf_stall, 64'd3);
    check("s2_perf_cycles", perf_cycles, 64'd20);
`endif
    wait_to(cyc + 2);

    // 3. start re-asserted mid-run is ignored
    t0 = cyc; push_run(t0, 0, 1000000); start = 1'b1;
    wait_to(t0 + 1); start = 1'b0;
    wait_to(t0 + 5); start = 1'b1;
    wait_to(t0 + 6); start = 1'b0;
    wait_to(t0 + 18);
    check_drained("s3");
    wait_to(cyc + 2);

    // 4. reset in cycle 6 aborts, restart in cycle 8
    t0 = cyc; push_run(t0, 0, t0 + 6); start = 1'b1;
    wait_to(t0 + 1); start = 1'b0;
    wait_to(t0 + 6); reset = 1'b1;
    wait_to(t0 + 7); reset = 1'b0;
    check("s4_outs_after_reset", {busy, done, in_rd_en, w_rd_en, accum_en, accum_sload, out_wr_en,
                                  bank_sel, in_addr_a, in_addr_b, w_addr, out_addr}, 64'd0);
    wait_to(t0 + 8);
    check_drained("s4a");
    t1 = cyc; push_run(t1, 0, 1000000); start = 1'b1;
    wait_to(t1 + 1); start = 1'b0;
    wait_to(t1 + 18);
    check_drained("s4b");
    wait_to(cyc + 2);

    // 5. back-to-back runs at cycle 0 and 18
    t0 = cyc; push_run(t0, 0, 1000000); start = 1'b1;
    wait_to(t0 + 1); start = 1'b0;
    wait_to(t0 + 18);
`ifdef FC_SCHED_PERF_EN
    check("s5_perf_cycles_run1", perf_cycles, 64'd17);
`endif
    t1 = cyc; push_run(t1, 0, 1000000); start = 1'b1;
    wait_to(t1 + 1); start = 1'b0;
    wait_to(t0 + 36);
    check_drained("s5");
`ifdef FC_SCHED_PERF_EN
    check("s5_perf_cycles_run2", perf_cycles, 64'd17);
`endif
    wait_to(cyc + 2);

    // 6. RD_LAT=1 instance
    t0 = cyc; start1 = 1'b1;
    wait_to(t0 + 1); start1 = 1'b0;
    check("s6_sload_c1", 64'(accum_sload1), 64'd0);
    check("s6_rd_en_c1", 64'(in_rd_en1), 64'd1);
    wait_to(t0 + 2);
    check("s6_sload_c2", 64'(accum_sload1), 64'd1);
    check("s6_en_c2", 64'(accum_en1), 64'd1);
    wait_to(t0 + 14);
    check("s6_done_c14", 64'(done1), 64'd0);
    wait_to(t0 + 15);
    check("s6_done_c15", 64'(done1), 64'd1);
    wait_to(t0 + 16);
    check("s6_idle_c16", 64'(busy1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
